// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and helpers for the spike rate decoder (package spike_decoder_pkg).
// Holds the decoder FSM state encoding, the saturating-increment helper and
// the default count width shared with the spiking network.
package spike_decoder_pkg;

  // Default per-neuron spike count width, shared with the network datapath.
  localparam int SPIKE_CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } srd_state_e;

  // Returns count+1, but sticks at the all-ones value of a 'width'-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (count >= max_val) ? max_val : (count + 32'd1);
  endfunction

endpackage

// File: rtl/spike_rate_decoder_counter_sat.sv
// Per-channel saturating spike counter (module spike_counter_sat).
// Synchronous clear has priority over increment; the value holds otherwise.
module spike_counter_sat
  import spike_decoder_pkg::*;
#(
  parameter int CNT_W = SPIKE_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;

  // Next value with saturation at all-ones.
  always_comb begin
    w_next = CNT_W'(sat_inc(32'(r_count), CNT_W));
  end

  // Count register: cleared on a new window, bumped on each sampled spike.
  // NOTE: counters are reset explicitly so a reset mid-window can never leak old spikes into the next result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per output channel over a fixed window,
// then scans the counts sequentially for the argmax (lowest index wins ties)
// and presents the class index/count on a valid/ready result interface.
// Optional feature macro: SPIKE_RATE_DECODER_COUNTS_EN exposes raw counts on o_counts.
module spike_rate_decoder
  import spike_decoder_pkg::*;
#(
  parameter int M      = 3,
  parameter int WINDOW = 64,
  parameter int CNT_W  = SPIKE_CNT_W_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_start,
  input  logic [M-1:0]                   i_spike_in,
  input  logic                           i_out_ready,
  output logic                           o_busy,
  output logic                           o_result_valid,
  output logic [((M>1)?$clog2(M):1)-1:0] o_winner,
  output logic [CNT_W-1:0]               o_winner_count,
`ifdef SPIKE_RATE_DECODER_COUNTS_EN
  output logic [M*CNT_W-1:0]             o_counts,
`endif
  output logic                           o_tie
);

  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam int WIN_W = $clog2(WINDOW + 1);

  srd_state_e       r_state;
  srd_state_e       w_next_state;
  logic [WIN_W-1:0] r_win_cnt;
  logic [IDX_W-1:0] r_scan_idx;
  logic [IDX_W-1:0] r_winner;
  logic [CNT_W-1:0] r_max;
  logic             r_tie;
  logic [CNT_W-1:0] w_counts [M];
  logic [CNT_W-1:0] w_scan_cnt;
  logic             w_clr;
  logic             w_accum;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: window length, scan length and result handshake.
  // NOTE: defaults are assigned first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = ACCUM;
      ACCUM:   if (r_win_cnt == WIN_W'(WINDOW - 1)) w_next_state = ARGMAX;
      ARGMAX:  if (r_scan_idx == IDX_W'(M - 1)) w_next_state = DONE;
      DONE:    if (i_out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_clr   = (r_state == IDLE) && i_start;
  assign w_accum = (r_state == ACCUM);

  for (genvar j = 0; j < M; j++) begin : g_cnt
    spike_counter_sat #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_clr),
      .i_inc   (w_accum && i_spike_in[j]),
      .o_count (w_counts[j])
    );
`ifdef SPIKE_RATE_DECODER_COUNTS_EN
    assign o_counts[j*CNT_W +: CNT_W] = w_counts[j];
`endif
  end

  // Select the count of the channel currently being scanned.
  always_comb begin
    w_scan_cnt = w_counts[0];
    for (int j = 1; j < M; j++) begin
      if (r_scan_idx == IDX_W'(j)) w_scan_cnt = w_counts[j];
    end
  end

  // Window sample counter: restarts on start, advances once per sampled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_cnt <= '0;
    end else if (w_clr) begin
      r_win_cnt <= '0;
    end else if (w_accum) begin
      r_win_cnt <= r_win_cnt + WIN_W'(1);
    end
  end

  // Argmax scan: channel 0 seeds the running max; later channels replace it
  // only when strictly greater, and an equal count flags a tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_idx <= '0;
      r_winner   <= '0;
      r_max      <= '0;
      r_tie      <= 1'b0;
    end else if (w_clr) begin
      r_scan_idx <= '0;
    end else if (r_state == ARGMAX) begin
      r_scan_idx <= r_scan_idx + IDX_W'(1);
      if (r_scan_idx == '0) begin
        r_max    <= w_scan_cnt;
        r_winner <= '0;
        r_tie    <= 1'b0;
      end else if (w_scan_cnt > r_max) begin
        r_max    <= w_scan_cnt;
        r_winner <= r_scan_idx;
        r_tie    <= 1'b0;
      end else if (w_scan_cnt == r_max) begin
        r_tie    <= 1'b1;
      end
    end
  end

  assign o_busy         = (r_state != IDLE);
  assign o_result_valid = (r_state == DONE);
  assign o_winner       = r_winner;
  assign o_winner_count = r_max;
  assign o_tie          = r_tie;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: argmax, tie, start-cycle exclusion,
// backpressure with ignored start, reset mid-window and counter saturation.
// Instance a: M=3, WINDOW=8, CNT_W=8. Instance b: M=3, WINDOW=20, CNT_W=3.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset;

  logic       a_start, a_ready, a_busy, a_valid, a_tie;
  logic [2:0] a_spike;
  logic [1:0] a_winner;
  logic [7:0] a_count;
`ifdef SPIKE_RATE_DECODER_COUNTS_EN
  logic [23:0] a_counts;
  logic [8:0]  b_counts;
`endif

  logic       b_start, b_ready, b_busy, b_valid, b_tie;
  logic [2:0] b_spike;
  logic [1:0] b_winner;
  logic [2:0] b_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.M(3), .WINDOW(8), .CNT_W(8)) dut_a (
    .clk            (clk),
    .reset          (reset),
    .i_start        (a_start),
    .i_spike_in     (a_spike),
    .i_out_ready    (a_ready),
    .o_busy         (a_busy),
    .o_result_valid (a_valid),
    .o_winner       (a_winner),
    .o_winner_count (a_count),
`ifdef SPIKE_RATE_DECODER_COUNTS_EN
    .o_counts       (a_counts),
`endif
    .o_tie          (a_tie)
  );

  spike_rate_decoder #(.M(3), .WINDOW(20), .CNT_W(3)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .i_start        (b_start),
    .i_spike_in     (b_spike),
    .i_out_ready    (b_ready),
    .o_busy         (b_busy),
    .o_result_valid (b_valid),
    .o_winner       (b_winner),
    .o_winner_count (b_count),
`ifdef SPIKE_RATE_DECODER_COUNTS_EN
    .o_counts       (b_counts),
`endif
    .o_tie          (b_tie)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One window on instance a: e0 is the spike vector in the start cycle,
  // c0..c2 give each channel's spike at samples 1..8 (bit k = sample k+1).
  task automatic run_a(input string tag, input logic [2:0] e0,
                       input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    int n;
    a_start = 1'b1;
    a_spike = e0;
    tick();
    a_start = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      a_spike = {c2[k], c1[k], c0[k]};
      tick();
      n++;
    end
    a_spike = 3'b000;
    while (!a_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 11);
  endtask

  // Accept the pending result on instance a with out_ready held for one edge.
  task automatic release_a(input string tag);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check({tag, "_valid_drop"}, a_valid, 0);
    check({tag, "_busy_drop"},  a_busy,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset   = 1'b1;
    a_start = 1'b0; a_ready = 1'b0; a_spike = 3'b000;
    b_start = 1'b0; b_ready = 1'b0; b_spike = 3'b000;
    #12;
    check("rst_busy",   a_busy,   0);
    check("rst_valid",  a_valid,  0);
    check("rst_winner", a_winner, 0);
    check("rst_count",  a_count,  0);
    check("rst_tie",    a_tie,    0);
    reset = 1'b0;
    tick();

    // Basic argmax: ch1 every sample (8), ch0 every other (4), ch2 never.
    run_a("basic", 3'b000, 8'h55, 8'hFF, 8'h00);
    check("basic_valid",  a_valid,  1);
    check("basic_winner", a_winner, 1);
    check("basic_count",  a_count,  8);
    check("basic_tie",    a_tie,    0);
`ifdef SPIKE_RATE_DECODER_COUNTS_EN
    check("basic_counts", a_counts, {8'd0, 8'd8, 8'd4});
`endif
    release_a("basic");

    // Tie: ch0 and ch2 spike 5 times, ch1 3 times.
    run_a("tie", 3'b000, 8'h1F, 8'h07, 8'hF8);
    check("tie_winner", a_winner, 0);
    check("tie_count",  a_count,  5);
    check("tie_tie",    a_tie,    1);
    release_a("tie");

    // Backpressure: result held for 10 cycles, a start pulse in DONE is ignored.
    run_a("bp", 3'b000, 8'h55, 8'hFF, 8'h00);
    for (int i = 0; i < 10; i++) begin
      a_start = (i == 4);
      tick();
      a_start = 1'b0;
      check("bp_hold_valid",  a_valid,  1);
      check("bp_hold_busy",   a_busy,   1);
      check("bp_hold_winner", a_winner, 1);
      check("bp_hold_count",  a_count,  8);
      check("bp_hold_tie",    a_tie,    0);
    end
    release_a("bp");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_restart", a_busy, 0);
    end

    // Reset mid-ACCUM after 4 samples of spikes on every channel.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_spike = 3'b111;
    for (int i = 0; i < 4; i++) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy",   a_busy,   0);
    check("mid_rst_valid",  a_valid,  0);
    check("mid_rst_winner", a_winner, 0);
    check("mid_rst_count",  a_count,  0);
    check("mid_rst_tie",    a_tie,    0);
    a_spike = 3'b000;
    #2 reset = 1'b0;
    tick();
    run_a("post_rst", 3'b000, 8'h00, 8'h00, 8'h03);
    check("post_rst_winner", a_winner, 2);
    check("post_rst_count",  a_count,  2);
    check("post_rst_tie",    a_tie,    0);
    release_a("post_rst");

    // Start-cycle exclusion: spikes only in the E0 cycle.
    run_a("e0", 3'b111, 8'h00, 8'h00, 8'h00);
    check("e0_winner", a_winner, 0);
    check("e0_count",  a_count,  0);
    check("e0_tie",    a_tie,    1);
    release_a("e0");

    // Saturation on instance b: ch2 every sample (20 -> 7), ch0 every 4th (5).
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      b_spike = {1'b1, 1'b0, (k % 4 == 0)};
      tick();
      n++;
    end
    b_spike = 3'b000;
    while (!b_valid && n < 60) begin
      tick();
      n++;
    end
    check("sat_latency", n, 23);
    check("sat_winner",  b_winner, 2);
    check("sat_count",   b_count,  7);
    check("sat_tie",     b_tie,    0);
`ifdef SPIKE_RATE_DECODER_COUNTS_EN
    check("sat_counts", b_counts, {3'd7, 3'd0, 3'd5});
`endif
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("sat_valid_drop", b_valid, 0);
    check("sat_busy_drop",  b_busy,  0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Output-side rate decoder for the spiking network. It counts the spikes each output neuron fires over a fixed observation window, then picks the most active channel (argmax) and presents that class index and its count on a valid/ready result interface. It sits directly after the Layer 2 `spike_out` vector and is the network's classification readout.

## Interface
- `M`, default 3: number of spike channels (Layer 2 neurons), M ≥ 1.
- `WINDOW`, default 64: number of sampled cycles per observation window, WINDOW ≥ 1.
- `CNT_W`, default 8: per-channel counter width; counters saturate at 2^CNT_W−1.
- `IDX_W`, default `(M>1) ? $clog2(M) : 1`: winner index width (derived, do not override).

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request a new window; accepted only in IDLE.
- `spike_in[M]`  in  1 each  spike vector from Layer 2, sampled every ACCUM cycle.
- `busy`  out  1  high whenever state ≠ IDLE.
- `result_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `winner`  out  IDX_W  index of the channel with the highest count.
- `winner_count`  out  CNT_W  count of the winning channel.
- `tie`  out  1  another channel's count equals `winner_count`.
- `counts[M]`  out  CNT_W each  raw per-channel counts (only with `SPIKE_RATE_DECODER_COUNTS_EN`).

## Operation
- FSM states: IDLE, ACCUM, ARGMAX, DONE.
- IDLE: when `start`=1 at an edge, clear all counters and the window counter, then go to ACCUM.
- ACCUM: on each edge, each counter with `spike_in[j]`=1 increments, saturating at all-ones. The window counter increments. After WINDOW sampled edges, go to ARGMAX.
- ARGMAX: sequential scan, one channel per edge, j = 0..M−1.
  - Running max is replaced only when count[j] is strictly greater, so the lowest index wins ties.
  - `tie` is set if a later channel equals the running max. It is cleared when a strictly greater count replaces the max.
  - After M edges, go to DONE.
- DONE: `result_valid`=1. `winner`, `winner_count` and `tie` are held stable.
  - On an edge with `out_ready`=1, go to IDLE.
- `start` outside IDLE is ignored (not queued).
- All zero counts give `winner`=0, `winner_count`=0, `tie`=1 when M>1 (`tie`=0 when M=1).
- Reset mid-operation returns to IDLE. Counters are cleared and any in-flight result is discarded.

## Timing
- Reset values: `busy`=0, `result_valid`=0, `winner`=0, `winner_count`=0, `tie`=0, `counts`=0.
- Call the edge that accepts `start` E0.
- `spike_in` is sampled at edges E1..E_WINDOW. Spikes present in the E0 cycle are not counted.
- ARGMAX occupies edges E_WINDOW+1..E_WINDOW+M.
- `result_valid` is first high in the cycle after edge E_WINDOW+M.
  - Total latency from `start` acceptance to valid: WINDOW+M edges.
- If `out_ready` is held high, `result_valid` lasts exactly 1 cycle. `busy` falls in the same cycle.
- The earliest next `start` is accepted at the edge after the return to IDLE. Back-to-back period: WINDOW+M+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SPIKE_RATE_DECODER_COUNTS_EN` defined:
  - The `counts[M]` output port exists and drives the live counter values.
  - Counters update during ACCUM and are held through ARGMAX and DONE until the next `start`.
- Not defined:
  - The port is absent.
  - Counters are internal only.
  - Behaviour is otherwise identical.

## Structure
- Package `spike_decoder_pkg` holds:
  - the FSM state enum `srd_state_e` (IDLE, ACCUM, ARGMAX, DONE);
  - the function `sat_inc(count, width)`;
  - the localparam default for `SPIKE_CONTRIBUTION`-compatible count widths, shared with the network.
- Sub-module `spike_counter_sat` is a saturating counter with `clr`/`inc` inputs. It is instantiated M times in a generate loop.

## Test plan
- Basic argmax: M=3, WINDOW=8; channel 1 spikes every cycle, channel 0 every other cycle, channel 2 never → `winner`=1, `winner_count`=8, `tie`=0, with `result_valid` rising WINDOW+M=11 edges after E0.
- Tie: channels 0 and 2 each spike 5 times, channel 1 spikes 3 times → `winner`=0, `winner_count`=5, `tie`=1.
- Saturation: CNT_W=3, WINDOW=20; channel 2 spikes every cycle → `winner_count`=7, `winner`=2.
- Backpressure and ignored start: hold `out_ready`=0 for 10 cycles and pulse `start` during DONE → outputs stay stable with `busy`=1. When `out_ready`=1, one transfer occurs, followed by IDLE with no new window started.
- Reset mid-ACCUM: assert `reset` at sample 4 → all outputs 0 immediately. A new `start` gives counts that exclude the pre-reset spikes.
- Start-cycle exclusion: a spike only in the E0 cycle, none afterwards → `winner_count`=0, `winner`=0, `tie`=1.
